// File: rtl/sm4_pkg.sv
// SM4 key-schedule shared definitions: FK constants, CK generation,
// the L' diffusion and the legal round-unroll factors.
package sm4_pkg;

    localparam int NUM_RK = 32;

    localparam logic [127:0] FK =
        128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic bit unroll_ok(input int u);
        return (u == 1) || (u == 2) || (u == 4) || (u == 8);
    endfunction

    // Byte j of CK_i is (28i + 7j) mod 256; 8-bit arithmetic does the mod.
    function automatic logic [7:0] ck_byte(
        input logic [5:0] i,
        input logic [1:0] j
    );
        return 8'({2'b00, i} * 8'd28 + {6'b0, j} * 8'd7);
    endfunction

    function automatic logic [31:0] ck_word(input logic [5:0] i);
        return {ck_byte(i, 2'd0), ck_byte(i, 2'd1),
                ck_byte(i, 2'd2), ck_byte(i, 2'd3)};
    endfunction

    function automatic logic [31:0] l_prime(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sm4_sbox.sv
// SM4 byte substitution box, purely combinational table lookup.
module sm4_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    localparam logic [0:255][7:0] TBL = {
        128'hd690e9fe_cce13db7_16b614c2_28fb2c05,
        128'h2b679a76_2abe04c3_aa441326_49860699,
        128'h9c4250f4_91ef987a_33540b43_edcfac62,
        128'he4b31ca9_c908e895_80df94fa_758f3fa6,
        128'h4707a7fc_f37317ba_83593c19_e6854fa8,
        128'h686b81b2_7164da8b_f8eb0f4b_70569d35,
        128'h1e240e5e_6358d1a2_25227c3b_01217887,
        128'hd4004657_9fd32752_4c3602e7_a0c4c89e,
        128'heabf8ad2_40c738b5_a3f7f2ce_f96115a1,
        128'he0ae5da4_9b341a55_ad933230_f58cb1e3,
        128'h1df6e22e_8266ca60_c02923ab_0d534e6f,
        128'hd5db3745_defd8e2f_03ff6a72_6d6c5b51,
        128'h8d1baf92_bbddbc7f_11d95c41_1f105ad8,
        128'h0ac13188_a5cd7bbd_2d74d012_b8e5b4b0,
        128'h8969974a_0c96777e_65b9f109_c56ec684,
        128'h18f07dec_3adc4d20_79ee5f3e_d7cb3948
    };

    assign y = TBL[x];

endmodule

// File: rtl/sm4_key_expander.sv
// SM4 round-key expander: UNROLL rounds per clock into a 32-entry store,
// read back in encrypt or decrypt order through a registered port.
module sm4_key_expander
    import sm4_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] mkey_i,
    input  logic         decrypt_i,
    input  logic [4:0]   rk_rd_idx_i,
    output logic [31:0]  rk_rd_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         keys_valid_o
);

    if (!unroll_ok(UNROLL)) begin : g_bad_unroll
        $fatal(1, "sm4_key_expander: UNROLL must be 1, 2, 4 or 8");
    end

    localparam logic [5:0] LAST_CNT = 6'(NUM_RK - UNROLL);

    state_e            state_q;
    state_e            state_d;
    logic [5:0]        cnt_q;
    logic [0:3][31:0]  k_q;
    logic [31:0]       store [NUM_RK];
    logic [31:0]       rk [UNROLL];
    logic              mode_q;
    logic              done_q;
    logic              valid_q;
    logic [31:0]       rd_q;
    logic              accept;
    logic              last;

    // Each round sees the window left by the previous one; round 0 sees k_q.
    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [31:0] w0, w1, w2, w3;
        logic [31:0] t_in;
        logic [31:0] t_sub;
        logic [31:0] nk;

        if (u == 0) begin : g_head
            assign {w0, w1, w2, w3} = k_q;
        end else begin : g_link
            assign {w0, w1, w2, w3} = {g_round[u-1].w1, g_round[u-1].w2,
                                       g_round[u-1].w3, g_round[u-1].nk};
        end

        assign t_in = w1 ^ w2 ^ w3 ^ ck_word(cnt_q + 6'(u));

        for (genvar b = 0; b < 4; b++) begin : g_sbox
            sm4_sbox u_sbox (
                .x (t_in[8*b +: 8]),
                .y (t_sub[8*b +: 8])
            );
        end

        assign nk    = w0 ^ l_prime(t_sub);
        assign rk[u] = nk;
    end

    always_ff @(posedge clk) begin : p_state
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : p_next
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST_CNT) state_d = ST_IDLE;
        endcase
    end

    always_comb begin : p_out
        busy_o = (state_q == ST_RUN);
        accept = (state_q == ST_IDLE) && start_i;
        last   = (state_q == ST_RUN) && (cnt_q == LAST_CNT);
    end

    always_ff @(posedge clk) begin : p_ctrl
        if (rst) begin
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            done_q <= last;
            // Decrypt order reads entry 31-idx, which is ~idx in 5 bits.
            rd_q   <= store[mode_q ? ~rk_rd_idx_i : rk_rd_idx_i];
            if (accept) begin
                cnt_q   <= '0;
                mode_q  <= decrypt_i;
                valid_q <= 1'b0;
            end else if (busy_o) begin
                cnt_q <= cnt_q + 6'(UNROLL);
                if (last) valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin : p_data
        if (accept) begin
            k_q <= mkey_i ^ FK;
        end else if (busy_o) begin
            k_q <= {g_round[UNROLL-1].w1, g_round[UNROLL-1].w2,
                    g_round[UNROLL-1].w3, g_round[UNROLL-1].nk};
            for (int u = 0; u < UNROLL; u++) begin
                store[5'(cnt_q[4:0] + 5'(u))] <= rk[u];
            end
        end
    end

    assign rk_rd_o      = rd_q;
    assign done_o       = done_q;
    assign keys_valid_o = valid_q;

endmodule

// File: tb/tb_sm4_key_expander.sv
// Bench for sm4_key_expander: four unroll variants side by side against
// a word-level SM4 key-schedule model.
module tb_sm4_key_expander;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [127:0] mkey_i;
    logic         decrypt_i;
    logic [4:0]   rk_rd_idx_i;

    logic [3:0][31:0] rd;
    logic [3:0]       busy;
    logic [3:0]       done;
    logic [3:0]       valid;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] MK0 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fe_cce13db7_16b614c2_28fb2c05,
        128'h2b679a76_2abe04c3_aa441326_49860699,
        128'h9c4250f4_91ef987a_33540b43_edcfac62,
        128'he4b31ca9_c908e895_80df94fa_758f3fa6,
        128'h4707a7fc_f37317ba_83593c19_e6854fa8,
        128'h686b81b2_7164da8b_f8eb0f4b_70569d35,
        128'h1e240e5e_6358d1a2_25227c3b_01217887,
        128'hd4004657_9fd32752_4c3602e7_a0c4c89e,
        128'heabf8ad2_40c738b5_a3f7f2ce_f96115a1,
        128'he0ae5da4_9b341a55_ad933230_f58cb1e3,
        128'h1df6e22e_8266ca60_c02923ab_0d534e6f,
        128'hd5db3745_defd8e2f_03ff6a72_6d6c5b51,
        128'h8d1baf92_bbddbc7f_11d95c41_1f105ad8,
        128'h0ac13188_a5cd7bbd_2d74d012_b8e5b4b0,
        128'h8969974a_0c96777e_65b9f109_c56ec684,
        128'h18f07dec_3adc4d20_79ee5f3e_d7cb3948
    };

    logic [31:0] rk_ref [32];

    always #5 clk = ~clk;

    sm4_key_expander #(.UNROLL(1)) u_x1 (
        .clk (clk), .rst (rst), .start_i (start_i), .mkey_i (mkey_i),
        .decrypt_i (decrypt_i), .rk_rd_idx_i (rk_rd_idx_i),
        .rk_rd_o (rd[0]), .busy_o (busy[0]), .done_o (done[0]),
        .keys_valid_o (valid[0])
    );
    sm4_key_expander #(.UNROLL(2)) u_x2 (
        .clk (clk), .rst (rst), .start_i (start_i), .mkey_i (mkey_i),
        .decrypt_i (decrypt_i), .rk_rd_idx_i (rk_rd_idx_i),
        .rk_rd_o (rd[1]), .busy_o (busy[1]), .done_o (done[1]),
        .keys_valid_o (valid[1])
    );
    sm4_key_expander #(.UNROLL(4)) u_x4 (
        .clk (clk), .rst (rst), .start_i (start_i), .mkey_i (mkey_i),
        .decrypt_i (decrypt_i), .rk_rd_idx_i (rk_rd_idx_i),
        .rk_rd_o (rd[2]), .busy_o (busy[2]), .done_o (done[2]),
        .keys_valid_o (valid[2])
    );
    sm4_key_expander #(.UNROLL(8)) u_x8 (
        .clk (clk), .rst (rst), .start_i (start_i), .mkey_i (mkey_i),
        .decrypt_i (decrypt_i), .rk_rd_idx_i (rk_rd_idx_i),
        .rk_rd_o (rd[3]), .busy_o (busy[3]), .done_o (done[3]),
        .keys_valid_o (valid[3])
    );

    // Straight from the cipher definition: K words, CK from 28i+7j.
    function automatic void model(input logic [127:0] mk);
        logic [127:0] fk;
        logic [31:0]  k [36];
        logic [31:0]  t;
        logic [31:0]  b;
        logic [31:0]  ck;
        fk = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
        for (int i = 0; i < 4; i++) begin
            k[i] = mk[127-32*i -: 32] ^ fk[127-32*i -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) begin
                ck[31-8*j -: 8] = 8'((28 * i + 7 * j) % 256);
            end
            t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck;
            for (int j = 0; j < 4; j++) begin
                b[31-8*j -: 8] = SBOX[t[31-8*j -: 8]];
            end
            b = b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
            k[i+4]    = k[i] ^ b;
            rk_ref[i] = k[i+4];
        end
    endfunction

    function automatic int ncyc(input int k);
        return 32 >> k;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start, then watch every variant; optional stray start or reset.
    task automatic run(input logic [127:0] mk, input logic dec,
                       input int poke_at, input int rst_at);
        int busy_n [4];
        int done_n [4];
        int done_at [4];
        for (int k = 0; k < 4; k++) begin
            busy_n[k]  = 0;
            done_n[k]  = 0;
            done_at[k] = -1;
        end
        mkey_i    = mk;
        decrypt_i = dec;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        mkey_i    = ~mk;
        decrypt_i = ~dec;
        for (int c = 0; c < 40; c++) begin
            if (c != 0) begin
                tick();
                start_i = 1'b0;
                rst     = 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                if (c == 0) begin
                    chk($sformatf("valid_clr_on_start[U%0d]", 1 << k),
                        32'(valid[k]), 32'd0);
                end
                if (rst_at >= 0 && c == rst_at + 1) begin
                    chk($sformatf("busy_after_rst[U%0d]", 1 << k),
                        32'(busy[k]), 32'd0);
                end
                if (busy[k]) busy_n[k]++;
                if (done[k]) begin
                    done_n[k]++;
                    done_at[k] = c;
                end
            end
            if (c == poke_at) begin
                mkey_i  = {4{32'hDEADBEEF}};
                start_i = 1'b1;
            end
            if (c == rst_at) rst = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            if (rst_at >= 0) begin
                chk($sformatf("abort_done_n[U%0d]", 1 << k),
                    32'(done_n[k]), 32'd0);
                chk($sformatf("abort_valid[U%0d]", 1 << k),
                    32'(valid[k]), 32'd0);
            end else begin
                chk($sformatf("done_n[U%0d]", 1 << k),
                    32'(done_n[k]), 32'd1);
                chk($sformatf("done_at[U%0d]", 1 << k),
                    32'(done_at[k]), 32'(ncyc(k)));
                chk($sformatf("busy_n[U%0d]", 1 << k),
                    32'(busy_n[k]), 32'(ncyc(k)));
                chk($sformatf("valid_end[U%0d]", 1 << k),
                    32'(valid[k]), 32'd1);
            end
        end
    endtask

    task automatic rd_const(input logic [4:0] idx, input logic [31:0] exp);
        rk_rd_idx_i = idx;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("kat_idx%0d[U%0d]", idx, 1 << k), rd[k], exp);
        end
    endtask

    task automatic rd_model(input logic [4:0] idx, input logic dec,
                            input int kmask);
        logic [31:0] exp;
        exp = dec ? rk_ref[31 - int'(idx)] : rk_ref[idx];
        rk_rd_idx_i = idx;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (kmask[k]) begin
                chk($sformatf("rnd_idx%0d_dec%0d[U%0d]", idx, dec, 1 << k),
                    rd[k], exp);
            end
        end
    endtask

    initial begin
        logic [127:0] mk;
        logic [127:0] mk2;
        logic         dec;
        int           hit;

        rst         = 1'b1;
        start_i     = 1'b0;
        mkey_i      = '0;
        decrypt_i   = 1'b0;
        rk_rd_idx_i = '0;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_busy[U%0d]", 1 << k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst_done[U%0d]", 1 << k), 32'(done[k]), 32'd0);
            chk($sformatf("rst_valid[U%0d]", 1 << k), 32'(valid[k]), 32'd0);
            chk($sformatf("rst_rd[U%0d]", 1 << k), rd[k], 32'd0);
        end

        // Reset wins over a simultaneous start.
        start_i = 1'b1;
        mkey_i  = MK0;
        tick();
        start_i = 1'b0;
        rst     = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_vs_start[U%0d]", 1 << k),
                32'(busy[k]), 32'd0);
        end

        run(MK0, 1'b0, -1, -1);
        rd_const(5'd0, 32'hF12186F9);
        rd_const(5'd1, 32'h41662B61);
        rd_const(5'd31, 32'h9124A012);

        run(MK0, 1'b1, -1, -1);
        rd_const(5'd0, 32'h9124A012);
        rd_const(5'd31, 32'hF12186F9);

        run(MK0, 1'b0, 3, -1);
        rd_const(5'd0, 32'hF12186F9);
        rd_const(5'd1, 32'h41662B61);
        rd_const(5'd31, 32'h9124A012);

        run({4{32'h5A5A5A5A}}, 1'b0, -1, 3);
        run(MK0, 1'b0, -1, -1);
        rd_const(5'd0, 32'hF12186F9);
        rd_const(5'd31, 32'h9124A012);

        for (int n = 0; n < 4; n++) begin
            mk  = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            model(mk);
            run(mk, dec, -1, -1);
            rd_model(5'd0, dec, 15);
            rd_model(5'd31, dec, 15);
            for (int r = 0; r < 4; r++) begin
                rd_model(5'($urandom_range(0, 31)), dec, 15);
            end
        end

        // Back-to-back start in the cycle done is visible, per variant.
        for (int k = 0; k < 4; k++) begin
            mk  = {$urandom, $urandom, $urandom, $urandom};
            mk2 = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            mkey_i    = mk;
            decrypt_i = 1'b0;
            start_i   = 1'b1;
            tick();
            start_i   = 1'b0;
            hit = -1;
            for (int c = 0; c < 40; c++) begin
                if (c != 0) tick();
                if (done[k]) begin
                    hit = c;
                    break;
                end
            end
            chk($sformatf("b2b_first_done[U%0d]", 1 << k),
                32'(hit), 32'(ncyc(k)));
            mkey_i    = mk2;
            decrypt_i = dec;
            start_i   = 1'b1;
            tick();
            start_i   = 1'b0;
            chk($sformatf("b2b_valid_drop[U%0d]", 1 << k),
                32'(valid[k]), 32'd0);
            chk($sformatf("b2b_busy[U%0d]", 1 << k), 32'(busy[k]), 32'd1);
            hit = -1;
            for (int c = 0; c < 40; c++) begin
                if (c != 0) tick();
                if (valid[k]) begin
                    hit = c;
                    break;
                end
            end
            chk($sformatf("b2b_valid_rise[U%0d]", 1 << k),
                32'(hit), 32'(ncyc(k)));
            repeat (40) tick();
            model(mk2);
            rd_model(5'd0, dec, 1 << k);
            rd_model(5'($urandom_range(0, 31)), dec, 1 << k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
